// File: rtl/pic_pkg.sv
// Shared definitions for the programmable interrupt controller:
// register addresses, command opcodes and mode bit positions.
package pic_pkg;

    localparam logic [1:0] ADDR_IMR  = 2'd0;
    localparam logic [1:0] ADDR_BASE = 2'd1;
    localparam logic [1:0] ADDR_CMD  = 2'd2;
    localparam logic [1:0] ADDR_IRR  = 2'd2;
    localparam logic [1:0] ADDR_ISR  = 2'd3;

    localparam logic [2:0] OP_NS_EOI   = 3'b001;
    localparam logic [2:0] OP_S_EOI    = 3'b010;
    localparam logic [2:0] OP_ROT_EOI  = 3'b011;
    localparam logic [2:0] OP_SET_PRIO = 3'b100;
    localparam logic [2:0] OP_SET_MODE = 3'b101;

    localparam int CMD_LVL_LSB   = 8;
    localparam int MODE_LTIM     = 8;
    localparam int MODE_AEOI     = 9;
    localparam int MODE_ROT_AEOI = 10;

    // Level that follows lvl in a ring of n levels
    function automatic int wrap_inc(input int lvl, input int n);
        return (lvl + 1 >= n) ? 0 : lvl + 1;
    endfunction

endpackage

// File: rtl/pic_prio_resolve.sv
// Rotating priority encoder: ptr names the highest-priority level,
// rank is the distance from ptr (0 = highest priority).
module pic_prio_resolve #(
    parameter int NUM_IR = 8
) (
    input  logic [NUM_IR-1:0]         req,
    input  logic [$clog2(NUM_IR)-1:0] ptr,
    output logic                      valid,
    output logic [$clog2(NUM_IR)-1:0] level,
    output logic [$clog2(NUM_IR)-1:0] rank
);

    localparam int IDW = $clog2(NUM_IR);

    logic [IDW-1:0] idx;

    // Scan lowest to highest priority so the last hit is the winner
    always_comb begin
        valid = 1'b0;
        level = '0;
        rank  = '0;
        idx   = '0;
        for (int i = NUM_IR - 1; i >= 0; i--) begin
            idx = IDW'((int'(ptr) + i) % NUM_IR);
            if (req[idx]) begin
                valid = 1'b1;
                level = idx;
                rank  = IDW'(i);
            end
        end
    end

endmodule

// File: rtl/pic_prio_ctrl.sv
// Programmable interrupt controller core: request latching, masking,
// rotating priority, acknowledge/vector handshake and EOI commands.
module pic_prio_ctrl
    import pic_pkg::*;
#(
    parameter int NUM_IR = 8,
    parameter int DATA_W = 16,
    parameter int VEC_W  = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [NUM_IR-1:0] IR,
    input  logic              WR_EN,
    input  logic              RD_EN,
    input  logic [1:0]        ADDR,
    input  logic [DATA_W-1:0] DIN,
    output logic [DATA_W-1:0] DOUT,
    output logic              INT,
    input  logic              INTA,
    output logic [VEC_W-1:0]  VECTOR,
    output logic              VEC_VALID
);

    localparam int IDW = $clog2(NUM_IR);

    logic [NUM_IR-1:0] irr, isr, imr, ir_prev;
    logic [NUM_IR-1:0] irr_d, isr_d, imr_d, isr_clr, isr_set;
    logic [VEC_W-1:0]  base, base_d;
    logic [IDW-1:0]    ptr, ptr_d;
    logic              ltim, aeoi, rot_aeoi;
    logic              ltim_d, aeoi_d, rot_aeoi_d;

    logic [NUM_IR-1:0] cand;
    logic              c_valid, s_valid;
    logic [IDW-1:0]    c_level, c_rank, s_level, s_rank;
    logic              int_next, ack_hit;
    logic [IDW-1:0]    lvl;
    logic [VEC_W-1:0]  vec;
    logic              cmd_wr, l_ok;
    logic [2:0]        op;
    logic [IDW-1:0]    cmd_l;
    logic [DATA_W-1:0] rd_data;
    logic              unused_din;

    assign unused_din = ^DIN;
    assign cand       = irr & ~imr;

    pic_prio_resolve #(.NUM_IR(NUM_IR)) u_cand (
        .req(cand), .ptr(ptr),
        .valid(c_valid), .level(c_level), .rank(c_rank)
    );

    pic_prio_resolve #(.NUM_IR(NUM_IR)) u_isr (
        .req(isr), .ptr(ptr),
        .valid(s_valid), .level(s_level), .rank(s_rank)
    );

    // Interrupt eligibility, acknowledged level and vector
    always_comb begin
        int_next = c_valid && (!s_valid || (c_rank < s_rank));
        ack_hit  = INTA && int_next;
        lvl      = ack_hit ? c_level : IDW'(NUM_IR - 1);
        vec      = {base[VEC_W-1:IDW], lvl};
        cmd_wr   = WR_EN && (ADDR == ADDR_CMD);
        op       = DIN[2:0];
        cmd_l    = DIN[CMD_LVL_LSB +: IDW];
        l_ok     = int'(cmd_l) < NUM_IR;
    end

    // Next-state for IRR/ISR/IMR/BASE/ptr/mode
    always_comb begin
        irr_d      = ltim ? IR : irr;
        isr_clr    = '0;
        isr_set    = '0;
        imr_d      = imr;
        base_d     = base;
        ptr_d      = ptr;
        ltim_d     = ltim;
        aeoi_d     = aeoi;
        rot_aeoi_d = rot_aeoi;

        // Ack clears the request first so a same-cycle edge wins
        if (!ltim && ack_hit) irr_d[lvl] = 1'b0;
        if (!ltim) irr_d = irr_d | (IR & ~ir_prev);

        if (ack_hit && !aeoi) isr_set[lvl] = 1'b1;
        if (ack_hit && aeoi && rot_aeoi)
            ptr_d = IDW'(wrap_inc(int'(lvl), NUM_IR));

        if (WR_EN && ADDR == ADDR_IMR)  imr_d  = DIN[NUM_IR-1:0];
        if (WR_EN && ADDR == ADDR_BASE) base_d = DIN[VEC_W-1:0];

        if (cmd_wr) begin
            case (op)
                OP_NS_EOI: begin
                    if (s_valid) isr_clr[s_level] = 1'b1;
                end
                OP_S_EOI: begin
                    if (l_ok) isr_clr[cmd_l] = 1'b1;
                end
                OP_ROT_EOI: begin
                    if (s_valid) begin
                        isr_clr[s_level] = 1'b1;
                        ptr_d = IDW'(wrap_inc(int'(s_level), NUM_IR));
                    end
                end
                OP_SET_PRIO: begin
                    if (l_ok) ptr_d = IDW'(wrap_inc(int'(cmd_l), NUM_IR));
                end
                OP_SET_MODE: begin
                    ltim_d     = DIN[MODE_LTIM];
                    aeoi_d     = DIN[MODE_AEOI];
                    rot_aeoi_d = DIN[MODE_ROT_AEOI];
                end
                default: ;
            endcase
        end

        isr_d = (isr & ~isr_clr) | isr_set;
    end

    // Read mux sees pre-write register values
    always_comb begin
        case (ADDR)
            ADDR_IMR:  rd_data = DATA_W'(imr);
            ADDR_BASE: rd_data = DATA_W'(base);
            ADDR_IRR:  rd_data = DATA_W'(irr);
            ADDR_ISR:  rd_data = DATA_W'(isr);
            default:   rd_data = '0;
        endcase
    end

    // State and registered outputs
    always_ff @(posedge CLK) begin
        if (RST) begin
            irr       <= '0;
            isr       <= '0;
            imr       <= '1;
            ir_prev   <= '0;
            base      <= '0;
            ptr       <= '0;
            ltim      <= 1'b0;
            aeoi      <= 1'b0;
            rot_aeoi  <= 1'b0;
            INT       <= 1'b0;
            VECTOR    <= '0;
            VEC_VALID <= 1'b0;
            DOUT      <= '0;
        end else begin
            irr       <= irr_d;
            isr       <= isr_d;
            imr       <= imr_d;
            ir_prev   <= IR;
            base      <= base_d;
            ptr       <= ptr_d;
            ltim      <= ltim_d;
            aeoi      <= aeoi_d;
            rot_aeoi  <= rot_aeoi_d;
            INT       <= int_next;
            VEC_VALID <= INTA;
            if (INTA)  VECTOR <= vec;
            if (RD_EN) DOUT   <= rd_data;
        end
    end

endmodule

// File: tb/tb_pic_prio_ctrl.sv
// Directed-vector bench for pic_prio_ctrl (NUM_IR=8, DATA_W=16, VEC_W=8).
// Inputs change 1 time unit after the rising edge; outputs are sampled there.
module tb_pic_prio_ctrl;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [7:0]  IR = '0;
    logic        WR_EN = 1'b0;
    logic        RD_EN = 1'b0;
    logic [1:0]  ADDR = '0;
    logic [15:0] DIN = '0;
    logic [15:0] DOUT;
    logic        INT;
    logic        INTA = 1'b0;
    logic [7:0]  VECTOR;
    logic        VEC_VALID;

    int nvec = 0;
    int nerr = 0;
    logic [15:0] d;

    pic_prio_ctrl #(.NUM_IR(8), .DATA_W(16), .VEC_W(8)) dut (
        .CLK(CLK), .RST(RST), .IR(IR), .WR_EN(WR_EN), .RD_EN(RD_EN),
        .ADDR(ADDR), .DIN(DIN), .DOUT(DOUT), .INT(INT), .INTA(INTA),
        .VECTOR(VECTOR), .VEC_VALID(VEC_VALID)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [15:0] v);
        WR_EN = 1'b1; ADDR = a; DIN = v;
        tick();
        WR_EN = 1'b0; DIN = '0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [15:0] v);
        RD_EN = 1'b1; ADDR = a;
        tick();
        RD_EN = 1'b0;
        v = DOUT;
    endtask

    task automatic ack();
        INTA = 1'b1;
        tick();
        INTA = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1; tick(); tick(); RST = 1'b0;
        nvec++; if (INT !== 1'b0) begin nerr++; $display("FAIL rst_int got %b exp 0", INT); end
        nvec++; if (VECTOR !== 8'h00) begin nerr++; $display("FAIL rst_vector got %h exp 00", VECTOR); end
        nvec++; if (VEC_VALID !== 1'b0) begin nerr++; $display("FAIL rst_vv got %b exp 0", VEC_VALID); end
        nvec++; if (DOUT !== 16'h0000) begin nerr++; $display("FAIL rst_dout got %h exp 0000", DOUT); end
        rd(2'd0, d);
        nvec++; if (d !== 16'h00FF) begin nerr++; $display("FAIL rst_imr got %h exp 00ff", d); end
        rd(2'd3, d);
        nvec++; if (d !== 16'h0000) begin nerr++; $display("FAIL rst_isr got %h exp 0000", d); end
    endtask

    task automatic test_basic();
        wr(2'd0, 16'h0000);
        wr(2'd1, 16'h00A8);
        IR = 8'h01;
        tick();
        nvec++; if (INT !== 1'b0) begin nerr++; $display("FAIL basic_int_t1 got %b exp 0", INT); end
        tick();
        nvec++; if (INT !== 1'b1) begin nerr++; $display("FAIL basic_int_t2 got %b exp 1", INT); end
        ack();
        nvec++; if (VECTOR !== 8'hA8) begin nerr++; $display("FAIL basic_vec got %h exp a8", VECTOR); end
        nvec++; if (VEC_VALID !== 1'b1) begin nerr++; $display("FAIL basic_vv got %b exp 1", VEC_VALID); end
        rd(2'd3, d);
        nvec++; if (VEC_VALID !== 1'b0) begin nerr++; $display("FAIL basic_vv_pulse got %b exp 0", VEC_VALID); end
        nvec++; if (d !== 16'h0001) begin nerr++; $display("FAIL basic_isr got %h exp 0001", d); end
        rd(2'd2, d);
        nvec++; if (d !== 16'h0000) begin nerr++; $display("FAIL basic_irr got %h exp 0000", d); end
    endtask

    task automatic test_nested();
        IR = 8'h82;
        tick(); tick(); tick();
        nvec++; if (INT !== 1'b0) begin nerr++; $display("FAIL nest_int_blocked got %b exp 0", INT); end
        rd(2'd2, d);
        nvec++; if (d !== 16'h0082) begin nerr++; $display("FAIL nest_irr got %h exp 0082", d); end
        wr(2'd2, 16'h0001);
        tick();
        nvec++; if (INT !== 1'b1) begin nerr++; $display("FAIL nest_int_after_eoi got %b exp 1", INT); end
        ack();
        nvec++; if (VECTOR !== 8'hA9) begin nerr++; $display("FAIL nest_vec1 got %h exp a9", VECTOR); end
        wr(2'd2, 16'h0001);
        ack();
        nvec++; if (VECTOR !== 8'hAF) begin nerr++; $display("FAIL nest_vec7 got %h exp af", VECTOR); end
        wr(2'd2, 16'h0001);
        IR = 8'h00;
        rd(2'd3, d);
        nvec++; if (d !== 16'h0000) begin nerr++; $display("FAIL nest_isr_clear got %h exp 0000", d); end
    endtask

    task automatic test_mask();
        wr(2'd0, 16'h00FE);
        IR = 8'h02;
        tick(); tick(); tick(); tick();
        nvec++; if (INT !== 1'b0) begin nerr++; $display("FAIL mask_int got %b exp 0", INT); end
        rd(2'd2, d);
        nvec++; if (d !== 16'h0002) begin nerr++; $display("FAIL mask_irr got %h exp 0002", d); end
        wr(2'd0, 16'h0000);
        tick();
        nvec++; if (INT !== 1'b1) begin nerr++; $display("FAIL mask_int_unmask got %b exp 1", INT); end
        ack();
        nvec++; if (VECTOR !== 8'hA9) begin nerr++; $display("FAIL mask_vec got %h exp a9", VECTOR); end
        wr(2'd2, 16'h0001);
        IR = 8'h00;
        tick();
    endtask

    task automatic test_rotate();
        IR = 8'h08;
        tick(); tick();
        ack();
        nvec++; if (VECTOR !== 8'hAB) begin nerr++; $display("FAIL rot_vec3 got %h exp ab", VECTOR); end
        wr(2'd2, 16'h0003);
        IR = 8'h00; tick();
        IR = 8'h18; tick();
        ack();
        nvec++; if (VECTOR !== 8'hAC) begin nerr++; $display("FAIL rot_first got %h exp ac", VECTOR); end
        wr(2'd2, 16'h0001);
        ack();
        nvec++; if (VECTOR !== 8'hAB) begin nerr++; $display("FAIL rot_second got %h exp ab", VECTOR); end
        wr(2'd2, 16'h0001);
        wr(2'd2, 16'h0704);
        IR = 8'h00;
        tick();
    endtask

    task automatic test_spurious_aeoi();
        ack();
        nvec++; if (VECTOR !== 8'hAF) begin nerr++; $display("FAIL spur_vec got %h exp af", VECTOR); end
        nvec++; if (VEC_VALID !== 1'b1) begin nerr++; $display("FAIL spur_vv got %b exp 1", VEC_VALID); end
        rd(2'd3, d);
        nvec++; if (d !== 16'h0000) begin nerr++; $display("FAIL spur_isr got %h exp 0000", d); end
        wr(2'd2, 16'h0205);
        IR = 8'h04; tick();
        ack();
        nvec++; if (VECTOR !== 8'hAA) begin nerr++; $display("FAIL aeoi_vec got %h exp aa", VECTOR); end
        rd(2'd3, d);
        nvec++; if (d !== 16'h0000) begin nerr++; $display("FAIL aeoi_isr got %h exp 0000", d); end
        wr(2'd2, 16'h0005);
        IR = 8'h00;
        tick();
    endtask

    task automatic test_back_to_back();
        IR = 8'h06; tick();
        INTA = 1'b1;
        tick();
        nvec++; if (VECTOR !== 8'hA9 || VEC_VALID !== 1'b1) begin nerr++; $display("FAIL b2b_first got %h/%b exp a9/1", VECTOR, VEC_VALID); end
        tick();
        INTA = 1'b0;
        nvec++; if (VECTOR !== 8'hAF || VEC_VALID !== 1'b1) begin nerr++; $display("FAIL b2b_second got %h/%b exp af/1", VECTOR, VEC_VALID); end
        tick();
        nvec++; if (VEC_VALID !== 1'b0) begin nerr++; $display("FAIL b2b_end got %b exp 0", VEC_VALID); end
        wr(2'd2, 16'h0001);
        ack();
        nvec++; if (VECTOR !== 8'hAA) begin nerr++; $display("FAIL b2b_pending got %h exp aa", VECTOR); end
        wr(2'd2, 16'h0001);
        IR = 8'h00;
        tick();
    endtask

    task automatic test_rw_same();
        WR_EN = 1'b1; RD_EN = 1'b1; ADDR = 2'd0; DIN = 16'h0055;
        tick();
        WR_EN = 1'b0; RD_EN = 1'b0; DIN = '0;
        nvec++; if (DOUT !== 16'h0000) begin nerr++; $display("FAIL rw_old got %h exp 0000", DOUT); end
        tick();
        nvec++; if (DOUT !== 16'h0000) begin nerr++; $display("FAIL rw_hold got %h exp 0000", DOUT); end
        rd(2'd0, d);
        nvec++; if (d !== 16'h0055) begin nerr++; $display("FAIL rw_new got %h exp 0055", d); end
        wr(2'd0, 16'h0000);
    endtask

    task automatic test_reset_mid();
        IR = 8'h01; tick();
        INTA = 1'b1; RST = 1'b1;
        tick();
        INTA = 1'b0; RST = 1'b0; IR = 8'h00;
        nvec++; if (VEC_VALID !== 1'b0) begin nerr++; $display("FAIL rstmid_vv got %b exp 0", VEC_VALID); end
        nvec++; if (VECTOR !== 8'h00) begin nerr++; $display("FAIL rstmid_vec got %h exp 00", VECTOR); end
        nvec++; if (INT !== 1'b0) begin nerr++; $display("FAIL rstmid_int got %b exp 0", INT); end
        tick();
        nvec++; if (VEC_VALID !== 1'b0) begin nerr++; $display("FAIL rstmid_vv_late got %b exp 0", VEC_VALID); end
        wr(2'd0, 16'h0000);
        wr(2'd1, 16'h00A8);
        IR = 8'h01; tick();
        IR = 8'h00; tick();
        IR = 8'h01; INTA = 1'b1;
        tick();
        INTA = 1'b0;
        nvec++; if (VECTOR !== 8'hA8) begin nerr++; $display("FAIL coll_vec got %h exp a8", VECTOR); end
        rd(2'd2, d);
        nvec++; if (d !== 16'h0001) begin nerr++; $display("FAIL coll_irr got %h exp 0001", d); end
        rd(2'd3, d);
        nvec++; if (d !== 16'h0001) begin nerr++; $display("FAIL coll_isr got %h exp 0001", d); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_nested();
        test_mask();
        test_rotate();
        test_spurious_aeoi();
        test_back_to_back();
        test_rw_same();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
